// File: rtl/stack_calc_pkg.sv
// Shared definitions for the stack calculator: opcodes, FSM states, default sizes
// and the button-priority decoder.
package stack_calc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP_RD = 2'd1,
        OP_RD  = 2'd2,
        EXEC   = 2'd3
    } state_e;

    // Up beats Down beats Left beats Right when several pulses land together.
    function automatic op_e decode_op(input logic up, input logic down,
                                      input logic left, input logic right);
        op_e op;
        op = OP_NONE;
        if (up)         op = OP_PUSH;
        else if (down)  op = OP_POP;
        else if (left)  op = OP_ADD;
        else if (right) op = OP_SUB;
        return op;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Operand storage: one synchronous write port, one asynchronous read port,
// contents are never reset.
module stack_mem
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_calc_core.sv
// Stack engine: decodes button pulses into PUSH/POP/ADD/SUB, keeps the stack
// pointer and a cached top-of-stack, and reports depth and status.
module stack_calc_core
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       PerfectUp,
    input  logic                       PerfectDown,
    input  logic                       PerfectLeft,
    input  logic                       PerfectRight,
    input  logic [WIDTH-1:0]           SwitchValue,
    output logic [WIDTH-1:0]           Top,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Busy,
    output logic                       Error
);

    localparam int SPW = $clog2(DEPTH+1);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    op_e              cmd;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [AW-1:0]    second_addr;
    logic [WIDTH-1:0] second_data;
    logic [WIDTH-1:0] alu_out;

    function automatic logic [WIDTH-1:0] alu(input op_e op,
                                             input logic [WIDTH-1:0] second,
                                             input logic [WIDTH-1:0] top);
        logic [WIDTH-1:0] res;
        if (op == OP_SUB) res = second - top;
        else              res = second + top;
        return res;
    endfunction

    assign cmd         = decode_op(PerfectUp, PerfectDown, PerfectLeft, PerfectRight);
    // The only entry ever read is the one under the top, mem[SP-2].
    assign second_addr = sp_q[AW-1:0] - AW'(2);
    assign alu_out     = alu(op_q, b_q, top_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sp_d      = sp_q;
        top_d     = top_q;
        b_d       = b_q;
        busy_d    = busy_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q[AW-1:0];
        mem_wdata = SwitchValue;

        case (state_q)
            IDLE: begin
                case (cmd)
                    OP_PUSH: begin
                        if (sp_q == SP_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            err_d     = 1'b0;
                            mem_we    = 1'b1;
                            mem_waddr = sp_q[AW-1:0];
                            mem_wdata = SwitchValue;
                            top_d     = SwitchValue;
                            sp_d      = sp_q + SP_ONE;
                        end
                    end
                    OP_POP: begin
                        if (sp_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            err_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = POP_RD;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (sp_q < SP_TWO) begin
                            err_d = 1'b1;
                        end else begin
                            err_d   = 1'b0;
                            op_d    = cmd;
                            busy_d  = 1'b1;
                            state_d = OP_RD;
                        end
                    end
                    default: ;
                endcase
            end
            POP_RD: begin
                top_d   = (sp_q == SP_ONE) ? '0 : second_data;
                sp_d    = sp_q - SP_ONE;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            OP_RD: begin
                b_d     = second_data;
                state_d = EXEC;
            end
            EXEC: begin
                // The result replaces the second operand, which becomes the new top.
                mem_we    = 1'b1;
                mem_waddr = second_addr;
                mem_wdata = alu_out;
                top_d     = alu_out;
                sp_d      = sp_q - SP_ONE;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A reset edge must not complete a pending write.
        if (!RESETN) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            sp_q    <= '0;
            top_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sp_q    <= sp_d;
            top_q   <= top_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
        b_q <= b_d;
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (second_addr),
        .rdata (second_data)
    );

    assign Top   = top_q;
    assign Depth = sp_q;
    assign Empty = (sp_q == '0);
    assign Full  = (sp_q == SP_FULL);
    assign Busy  = busy_q;
    assign Error = err_q;

endmodule

// File: tb/tb_stack_calc_core.sv
// Self-checking bench for stack_calc_core: directed scenarios plus random
// command streams compared against a queue-based stack model.
module tb_stack_calc_core;

    localparam int W = 8;
    localparam int D = 8;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic         PerfectUp = 1'b0, PerfectDown = 1'b0;
    logic         PerfectLeft = 1'b0, PerfectRight = 1'b0;
    logic [W-1:0] SwitchValue = '0;
    logic [W-1:0] Top;
    logic [3:0]   Depth;
    logic         Empty, Full, Busy, Error;

    int checks = 0;
    int errors = 0;

    int unsigned stk[$];
    bit          m_err = 1'b0;

    stack_calc_core #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .PerfectUp    (PerfectUp),
        .PerfectDown  (PerfectDown),
        .PerfectLeft  (PerfectLeft),
        .PerfectRight (PerfectRight),
        .SwitchValue  (SwitchValue),
        .Top          (Top),
        .Depth        (Depth),
        .Empty        (Empty),
        .Full         (Full),
        .Busy         (Busy),
        .Error        (Error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_top();
        return (stk.size() > 0) ? stk[stk.size()-1] : 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".top"},   32'(Top),   m_top());
        check({tag, ".depth"}, 32'(Depth), stk.size());
        check({tag, ".empty"}, 32'(Empty), 32'(stk.size() == 0));
        check({tag, ".full"},  32'(Full),  32'(stk.size() == D));
        check({tag, ".busy"},  32'(Busy),  0);
        check({tag, ".error"}, 32'(Error), 32'(m_err));
    endtask

    // Issues one cycle of pulses, updates the model, waits the command latency
    // (checking Busy throughout), then compares all outputs. Optionally fires a
    // stray Down pulse while the engine is busy.
    task automatic cmd(input string tag, input bit u, input bit d, input bit l,
                       input bit r, input logic [W-1:0] v, input bit stray_down);
        int lat;
        int unsigned a, b;
        lat = 0;
        @(negedge CLK);
        PerfectUp = u; PerfectDown = d; PerfectLeft = l; PerfectRight = r;
        SwitchValue = v;
        @(posedge CLK);
        #1;
        PerfectUp = 0; PerfectDown = 0; PerfectLeft = 0; PerfectRight = 0;
        if (u) begin
            if (stk.size() == D) m_err = 1;
            else begin stk.push_back(v); m_err = 0; end
        end else if (d) begin
            if (stk.size() == 0) m_err = 1;
            else begin void'(stk.pop_back()); m_err = 0; lat = 1; end
        end else if (l || r) begin
            if (stk.size() < 2) m_err = 1;
            else begin
                a = stk.pop_back();
                b = stk.pop_back();
                stk.push_back(l ? ((b + a) % 256) : ((b - a) % 256));
                m_err = 0;
                lat = 2;
            end
        end
        for (int i = 0; i < lat; i++) begin
            check({tag, ".busy_win"}, 32'(Busy), 1);
            if (stray_down && i == 0) begin
                @(negedge CLK);
                PerfectDown = 1;
            end
            @(posedge CLK);
            #1;
            PerfectDown = 0;
        end
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESETN = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1;
        stk.delete();
        m_err = 0;
    endtask

    initial begin
        bit u, d, l, r;

        // Reset state
        do_reset();
        check_model("reset");

        // Basic ADD
        cmd("push5", 1, 0, 0, 0, 8'd5, 0);
        cmd("push3", 1, 0, 0, 0, 8'd3, 0);
        cmd("add",   0, 0, 1, 0, 8'd0, 0);
        check("add.top_is_8", 32'(Top), 8);
        check("add.depth_is_1", 32'(Depth), 1);

        // SUB wraps; ADD wraps
        do_reset();
        cmd("push3b", 1, 0, 0, 0, 8'd3, 0);
        cmd("push5b", 1, 0, 0, 0, 8'd5, 0);
        cmd("sub",    0, 0, 0, 1, 8'd0, 0);
        check("sub.top_fe", 32'(Top), 32'hFE);
        cmd("pushff", 1, 0, 0, 0, 8'hFF, 0);
        cmd("push02", 1, 0, 0, 0, 8'h02, 0);
        cmd("addwrap", 0, 0, 1, 0, 8'd0, 0);
        check("addwrap.top_01", 32'(Top), 1);

        // Fill, overflow, pop
        do_reset();
        for (int i = 1; i <= 8; i++) cmd("fill", 1, 0, 0, 0, W'(i), 0);
        check("fill.full", 32'(Full), 1);
        check("fill.top8", 32'(Top), 8);
        cmd("overflow", 1, 0, 0, 0, 8'd99, 0);
        check("overflow.err", 32'(Error), 1);
        check("overflow.depth", 32'(Depth), 8);
        cmd("pop_full", 0, 1, 0, 0, 8'd0, 0);
        check("pop_full.top7", 32'(Top), 7);
        check("pop_full.err0", 32'(Error), 0);

        // Underflow cases
        do_reset();
        cmd("pop_empty", 0, 1, 0, 0, 8'd0, 0);
        check("pop_empty.err", 32'(Error), 1);
        cmd("push9", 1, 0, 0, 0, 8'd9, 0);
        cmd("add_short", 0, 0, 1, 0, 8'd0, 0);
        check("add_short.err", 32'(Error), 1);
        check("add_short.top9", 32'(Top), 9);
        cmd("pop_last", 0, 1, 0, 0, 8'd0, 0);
        check("pop_last.top0", 32'(Top), 0);

        // Priority and ignored pulse while busy
        cmd("up_left", 1, 0, 1, 0, 8'd4, 0);
        check("up_left.top4", 32'(Top), 4);
        cmd("push6", 1, 0, 0, 0, 8'd6, 0);
        cmd("push2", 1, 0, 0, 0, 8'd2, 0);
        cmd("add_stray", 0, 0, 1, 0, 8'd0, 1);
        check("add_stray.depth", 32'(Depth), 2);
        cmd("all4", 0, 1, 1, 1, 8'd0, 0);

        // Reset during OP_RD
        cmd("pushA", 1, 0, 0, 0, 8'd10, 0);
        @(negedge CLK);
        PerfectLeft = 1;
        @(posedge CLK);
        #1;
        PerfectLeft = 0;
        check("midrst.busy_before", 32'(Busy), 1);
        RESETN = 0;
        @(posedge CLK);
        #1;
        RESETN = 1;
        stk.delete();
        m_err = 0;
        check_model("midrst");
        cmd("after_rst", 1, 0, 0, 0, 8'd1, 0);
        check("after_rst.top1", 32'(Top), 1);

        // Random command stream
        for (int n = 0; n < 400; n++) begin
            u = ($urandom_range(0, 99) < 40);
            d = ($urandom_range(0, 99) < 25);
            l = ($urandom_range(0, 99) < 25);
            r = ($urandom_range(0, 99) < 25);
            cmd("rand", u, d, l, r, W'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
